// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver, the UART transmitter and
// the UART FIFO.
//   uart_rx_state_t    : receive frame FSM states
//   UART_DATA_BITS     : data bits per frame (8N1)
//   UART_MIN_DIVISOR   : smallest usable clocks-per-bit value
//   uart_clamp_divisor : raises a divisor below the minimum up to the minimum
package uart_pkg;

  localparam int UART_DATA_BITS   = 8;
  localparam int UART_MIN_DIVISOR = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  function automatic logic [15:0] uart_clamp_divisor(input logic [15:0] div);
    return (div < 16'(UART_MIN_DIVISOR)) ? 16'(UART_MIN_DIVISOR) : div;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous first-word-fall-through FIFO. The head entry is
// always visible on o_rdata while o_valid is high.
//   i_clk    : clock
//   i_rst_n  : asynchronous active-low reset (empties the FIFO, clears storage)
//   i_push   : write request; accepted when not full, or when full and a pop
//              happens in the same cycle
//   i_wdata  : write data
//   i_pop    : read request; a pop happens when i_pop & o_valid
//   o_rdata  : head entry
//   o_valid  : FIFO not empty
//   o_full   : FIFO full
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_valid,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && o_valid;
  // When full, the slot freed by a simultaneous pop is the one being written.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a small FWFT receive FIFO.
//   clk         : system clock
//   reset_n     : asynchronous active-low reset
//   divisor     : clocks per bit (values below 4 act as 4), latched per frame
//   rxd         : asynchronous serial input, idle high
//   rx_data     : FIFO head byte, valid while rx_valid
//   rx_valid    : FIFO not empty
//   rx_ready    : consumer pop, taken when rx_valid & rx_ready
//   framing_err : one-cycle pulse, stop bit sampled low
//   break_det   : one-cycle pulse, all-zero byte with stop bit low
//   overrun     : one-cycle pulse, good byte dropped because FIFO full
//
// Frame FSM
//   state | meaning
//   IDLE  | waiting for a falling edge on the synchronised line
//   START | counting to mid start bit, then confirming it is still low
//   DATA  | sampling 8 data bits at mid-bit, LSB first
//   STOP  | sampling the stop bit, then push or report an error
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] divisor,
  input  logic        rxd,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        framing_err,
  output logic        break_det,
  output logic        overrun
);

  logic [SYNC_STAGES-1:0]    r_sync;
  logic                      r_rxs_d;
  uart_rx_state_t            r_state;
  logic [15:0]               r_cnt;
  logic [15:0]               r_div_l;
  logic [2:0]                r_bitn;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_framing_err;
  logic                      r_break_det;
  logic                      r_overrun;

  logic                      w_rxs;
  logic [15:0]               w_div_clamped;
  logic                      w_stop_hit;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_fifo_full;
  logic                      w_fifo_valid;
  logic [UART_DATA_BITS-1:0] w_fifo_rdata;
  logic                      w_overrun;

  assign w_rxs         = r_sync[SYNC_STAGES-1];
  assign w_div_clamped = uart_clamp_divisor(divisor);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= '1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], rxd};
      r_rxs_d <= w_rxs;
    end
  end

  assign w_stop_hit = (r_state == STOP) && (r_cnt == 16'd0);
  assign w_push     = w_stop_hit && w_rxs;
  assign w_pop      = rx_ready && w_fifo_valid;
  assign w_overrun  = w_push && w_fifo_full && !w_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_cnt         <= 16'd0;
      r_div_l       <= 16'(UART_MIN_DIVISOR);
      r_bitn        <= 3'd0;
      r_shift       <= '0;
      r_framing_err <= 1'b0;
      r_break_det   <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_framing_err <= 1'b0;
      r_break_det   <= 1'b0;
      r_overrun     <= w_overrun;
      case (r_state)
        IDLE: begin
          if (r_rxs_d && !w_rxs) begin
            r_div_l <= w_div_clamped;
            r_cnt   <= w_div_clamped >> 1;
            r_state <= START;
          end else if (r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        START: begin
          if (r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
          end else if (!w_rxs) begin
            r_cnt   <= r_div_l - 16'd1;
            r_bitn  <= 3'd0;
            r_state <= DATA;
          end else begin
            // line went back high before mid start bit: a glitch
            r_state <= IDLE;
          end
        end
        DATA: begin
          if (r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
          end else begin
            r_shift <= {w_rxs, r_shift[UART_DATA_BITS-1:1]};
            r_cnt   <= r_div_l - 16'd1;
            if (r_bitn == 3'(UART_DATA_BITS - 1)) begin
              r_state <= STOP;
            end else begin
              r_bitn <= r_bitn + 3'd1;
            end
          end
        end
        STOP: begin
          if (r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
          end else begin
            // a held-low line cannot retrigger: IDLE waits for a fresh edge
            r_state <= IDLE;
            if (!w_rxs) begin
              r_framing_err <= 1'b1;
              r_break_det   <= (r_shift == '0);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  uart_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_wdata (r_shift),
    .i_pop   (rx_ready),
    .o_rdata (w_fifo_rdata),
    .o_valid (w_fifo_valid),
    .o_full  (w_fifo_full)
  );

  assign rx_data     = w_fifo_rdata;
  assign rx_valid    = w_fifo_valid;
  assign framing_err = r_framing_err;
  assign break_det   = r_break_det;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  logic        clk;
  logic        reset_n;
  logic [15:0] divisor;
  logic        rxd;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        framing_err;
  logic        break_det;
  logic        overrun;

  int n_total = 0;
  int n_bad   = 0;

  int n_fe   = 0;
  int n_brk  = 0;
  int n_ovr  = 0;
  int n_rise = 0;
  logic prev_valid = 1'b0;

  int b_fe, b_brk, b_ovr, b_rise;

  uart_rx_fifo #(
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .divisor     (divisor),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .framing_err (framing_err),
    .break_det   (break_det),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (framing_err) n_fe++;
    if (break_det)   n_brk++;
    if (overrun)     n_ovr++;
    if (rx_valid && !prev_valid) n_rise++;
    prev_valid = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_fe = n_fe; b_brk = n_brk; b_ovr = n_ovr; b_rise = n_rise;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame with bt clocks per bit. pop_idx >= 0 raises rx_ready for
  // exactly one cycle at that clock of the stop bit. chg_bit >= 0 changes the
  // divisor input at the start of that bit (0 = start bit, 9 = stop bit).
  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input int bt,
                           input int pop_idx, input int chg_bit, input logic [15:0] new_div);
    logic [9:0] frame;
    frame = {stop_bit, d, 1'b0};
    @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      if (b == chg_bit) divisor = new_div;
      rxd = frame[b];
      for (int i = 0; i < bt; i++) begin
        rx_ready = (b == 9) && (i == pop_idx);
        @(negedge clk);
      end
      rx_ready = 1'b0;
    end
    rxd = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input int bt);
    send_byte(d, 1'b1, bt, -1, -1, 16'd0);
    idle(10);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, rx_data}, {24'd0, exp});
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    rxd      = 1'b1;
    divisor  = 16'd16;
    rx_ready = 1'b0;
    idle(3);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_data", {24'd0, rx_data}, 32'd0);
    chk("rst_pulses", {29'd0, framing_err, break_det, overrun}, 32'd0);
    reset_n = 1'b1;
    idle(5);

    // basic receive
    snap();
    send(8'hA5, 16);
    chk("basic_rise", n_rise - b_rise, 1);
    chk("basic_valid", {31'd0, rx_valid}, 32'd1);
    chk("basic_data", {24'd0, rx_data}, 32'h00A5);
    chk("basic_pulses", (n_fe - b_fe) + (n_brk - b_brk) + (n_ovr - b_ovr), 0);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("basic_popped", {31'd0, rx_valid}, 32'd0);
    @(negedge clk);
    rx_ready = 1'b0;

    // start glitch
    snap();
    @(negedge clk);
    rxd = 1'b0;
    idle(5);
    rxd = 1'b1;
    idle(40);
    chk("glitch_rise", n_rise - b_rise, 0);
    chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
    chk("glitch_pulses", (n_fe - b_fe) + (n_brk - b_brk) + (n_ovr - b_ovr), 0);
    send(8'h3C, 16);
    pop_expect("glitch_next", 8'h3C);

    // framing error
    snap();
    send_byte(8'h55, 1'b0, 16, -1, -1, 16'd0);
    idle(10);
    chk("ferr_fe", n_fe - b_fe, 1);
    chk("ferr_brk", n_brk - b_brk, 0);
    chk("ferr_valid", {31'd0, rx_valid}, 32'd0);

    // break: line low for 12 bit times
    idle(20);
    snap();
    @(negedge clk);
    rxd = 1'b0;
    idle(12 * 16);
    chk("brk_fe", n_fe - b_fe, 1);
    chk("brk_brk", n_brk - b_brk, 1);
    rxd = 1'b1;
    idle(60);
    chk("brk_after_fe", n_fe - b_fe, 1);
    chk("brk_after_brk", n_brk - b_brk, 1);
    chk("brk_valid", {31'd0, rx_valid}, 32'd0);

    // overrun
    snap();
    send(8'h01, 16);
    send(8'h02, 16);
    send(8'h03, 16);
    send(8'h04, 16);
    chk("ovr_none_yet", n_ovr - b_ovr, 0);
    send(8'h05, 16);
    chk("ovr_once", n_ovr - b_ovr, 1);
    pop_expect("ovr_r1", 8'h01);
    pop_expect("ovr_r2", 8'h02);
    pop_expect("ovr_r3", 8'h03);
    pop_expect("ovr_r4", 8'h04);
    @(negedge clk);
    chk("ovr_empty", {31'd0, rx_valid}, 32'd0);

    // full plus pop on the stop-sample cycle (3 + bt/2 clocks into stop bit)
    send(8'h10, 16);
    send(8'h11, 16);
    send(8'h12, 16);
    send(8'h13, 16);
    snap();
    send_byte(8'h77, 1'b1, 16, 11, -1, 16'd0);
    idle(10);
    chk("fullpop_ovr", n_ovr - b_ovr, 0);
    pop_expect("fullpop_r1", 8'h11);
    pop_expect("fullpop_r2", 8'h12);
    pop_expect("fullpop_r3", 8'h13);
    pop_expect("fullpop_r4", 8'h77);
    @(negedge clk);
    chk("fullpop_empty", {31'd0, rx_valid}, 32'd0);

    // reset mid-byte
    send(8'h42, 16);
    chk("rstmid_pre", {31'd0, rx_valid}, 32'd1);
    snap();
    @(negedge clk);
    rxd = 1'b0;
    idle(16);
    rxd = 1'b1;
    idle(16);
    rxd = 1'b0;
    idle(8);
    reset_n = 1'b0;
    rxd = 1'b1;
    idle(3);
    chk("rstmid_valid", {31'd0, rx_valid}, 32'd0);
    chk("rstmid_data", {24'd0, rx_data}, 32'd0);
    reset_n = 1'b1;
    idle(200);
    chk("rstmid_pulses", (n_fe - b_fe) + (n_brk - b_brk) + (n_ovr - b_ovr), 0);
    chk("rstmid_still_empty", {31'd0, rx_valid}, 32'd0);

    // divisor change mid-frame, then next frame at the new rate
    snap();
    divisor = 16'd16;
    send_byte(8'hC3, 1'b1, 16, -1, 3, 16'd8);
    idle(10);
    send(8'h5A, 8);
    chk("div_fe", n_fe - b_fe, 0);
    pop_expect("div_r16", 8'hC3);
    pop_expect("div_r8", 8'h5A);

    // divisor below minimum acts as 4
    divisor = 16'd2;
    send(8'h81, 4);
    pop_expect("clamp", 8'h81);
    @(negedge clk);
    chk("clamp_empty", {31'd0, rx_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
